packet_disassembly: RTL and testbench
=====================================

Name: packet_disassembly

Overview:
- Receive-side counterpart of the transmit packet assembly.
- Consumes 8b/10b-decoded symbols from one lane (after descramble/decode) at 2.5 and 5.0 GT/s.
- Recognises TS1, TS2, SKP, EIOS and FTS ordered sets and extracts TS fields.
- Maintains the consecutive-identical-TS count for the LTSSM in pcie_control.

Parameters:
- TS_CNT_W, 4, width of the consecutive-TS counter; the counter saturates at 2^TS_CNT_W-1.
- MAX_SKP, 5, maximum SKP symbols accepted after COM in one SKP OS.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- active_data_rate_i  in  active_data_rate_e  current link rate
- symbol_i  in  8  decoded symbol
- symbol_is_k_i  in  1  symbol is a K-code
- symbol_valid_i  in  1  symbol_i/symbol_is_k_i qualify this cycle
- ts_valid_o  out  1  one-cycle pulse: complete, well-formed TS received
- ts_type_o  out  1  0 = TS1, 1 = TS2; valid with ts_valid_o, held after
- link_num_o  out  8  symbol 1; 8'hF7 when PAD
- link_is_pad_o  out  1  symbol 1 was K23.7 PAD
- lane_num_o  out  8  symbol 2
- lane_is_pad_o  out  1  symbol 2 was PAD
- n_fts_o  out  8  symbol 3
- rate_id_o  out  8  symbol 4
- train_ctrl_o  out  8  symbol 5
- ts_consec_cnt_o  out  TS_CNT_W  number of consecutive identical TSs
- skp_det_o  out  1  pulse: SKP OS ended
- skp_cnt_o  out  3  SKP symbols in the last SKP OS
- eios_det_o  out  1  pulse: EIOS (COM IDL IDL IDL) received
- fts_det_o  out  1  pulse: FTS OS (COM FTS FTS FTS) received
- os_err_o  out  1  pulse: malformed ordered set aborted

Behaviour:
- Reset (rst_ni low at a clock edge):
  - All outputs go to 0.
  - State goes to HUNT.
  - Field registers and the previous-TS shadow are cleared.
  - Reset mid-OS discards the partial OS; no pulse is generated.
- Cycles with symbol_valid_i = 0: state, symbol index and outputs hold. Pulses are still only one cycle wide.
- Rate gating: if active_data_rate_i is not RATE_2_5GT or RATE_5_0GT, the FSM is forced to HUNT, no pulses fire, and field outputs hold.
- Latency: every detect or error pulse is registered and asserts the cycle after the last symbol of the OS is accepted. Field outputs update in the same cycle as ts_valid_o.
- FSM (one transition per accepted symbol):
  - HUNT: K28.5 COM -> OS_TYPE. Anything else stays in HUNT with no error.
  - OS_TYPE:
    - K28.0 SKP -> SKP_BODY, skp count = 1.
    - K28.3 IDL -> EIOS_BODY, idx = 2.
    - K28.1 FTS -> FTS_BODY, idx = 2.
    - D-symbol or PAD -> TS_BODY, capture link field, idx = 2.
    - COM -> OS_TYPE, error.
    - Other -> HUNT, error.
  - TS_BODY:
    - Symbols 2-5 are captured. Each must be a D-symbol, except symbol 2, which may be PAD.
    - Symbol 6 sets the type: D10.2 (8'h4A) = TS1, D5.2 (8'h45) = TS2.
    - Symbols 7-15 must equal the symbol-6 identifier.
    - After symbol 15: ts_valid_o pulses, then -> HUNT.
  - SKP_BODY:
    - SKP: count++.
    - First non-SKP: skp_det_o pulses with skp_cnt_o = count. That symbol is then reprocessed as a HUNT symbol, so a COM goes to OS_TYPE.
    - Count reaching MAX_SKP: pulse immediately, -> HUNT.
  - EIOS_BODY / FTS_BODY: two more IDL (resp. FTS) symbols are required, then the pulse fires and -> HUNT.
- Errors:
  - Any unexpected symbol inside TS/EIOS/FTS body pulses os_err_o.
  - If the offending symbol is COM -> OS_TYPE (resynchronise); otherwise -> HUNT.
  - A partial TS updates no field output.
- Consecutive counter:
  - On ts_valid_o, compare type, link, lane, n_fts, rate_id, train_ctrl and both PAD flags to the previous TS.
  - Equal -> cnt+1, saturating. Different, or first TS after reset -> cnt = 1.
  - eios_det_o clears the counter to 0.
  - os_err_o, SKP and FTS leave the counter unchanged.
- Simultaneous events: at most one pulse per cycle. This is guaranteed by sequencing, except that skp_det_o and an error can never coincide.

Decomposition:
- Shared package (register_pkg or a new pcie_symbols_pkg):
  - 8b/10b K-code constants: COM 8'hBC, SKP 8'h1C, IDL 8'h7C, FTS 8'h3C, PAD 8'hF7, EIE 8'hFC.
  - TS identifiers: TS1_ID 8'h4A, TS2_ID 8'h45.
  - Receive FSM enum rx_os_fsm_e.
  - ts_fields_t struct.
- No sub-module: the compare/counter logic stays inline.

Test Plan:
- TS1 with link 8'h00, lane 8'h01, n_fts 8'h20, rate 8'h02, ctrl 8'h00 and 10×8'h4A -> ts_valid_o=1, ts_type_o=0, fields match, ts_consec_cnt_o=1.
- 8 identical TS2 back-to-back, then one TS2 with lane 8'h02 -> counter runs 1..8, then resets to 1. With 20 identical TS2, the counter saturates at 15.
- COM SKP SKP SKP then COM (start of TS1) -> skp_det_o with skp_cnt_o=3, and the following TS1 is still decoded.
- COM IDL IDL IDL after 5 identical TS1 -> eios_det_o=1, ts_consec_cnt_o=0. COM FTS FTS FTS -> fts_det_o=1.
- TS1 corrupted at symbol 9 (8'h45), and a separate TS1 interrupted by COM at symbol 4 -> os_err_o each time, fields unchanged, and the following clean TS decodes.
- symbol_valid_i toggled every other cycle during a TS, rst_ni pulsed mid-TS, and active_data_rate_i set to 8 GT/s -> no pulses during reset or gating, all outputs 0 after reset, and the next clean TS after the rate is restored decodes normally.

Source files
------------

// File: rtl/packet_disassembly_pkg.sv
// Shared definitions for the receive-side ordered-set disassembler.
// Contents: 8b/10b K-code and TS identifier constants, link rate enum,
// receive FSM state enum and the captured TS field struct.
package packet_disassembly_pkg;

    // 8b/10b K-code symbol values (valid only with the K flag set)
    localparam logic [7:0] COM    = 8'hBC;  // K28.5
    localparam logic [7:0] SKP    = 8'h1C;  // K28.0
    localparam logic [7:0] IDL    = 8'h7C;  // K28.3
    localparam logic [7:0] FTS    = 8'h3C;  // K28.1
    localparam logic [7:0] PAD    = 8'hF7;  // K23.7
    localparam logic [7:0] EIE    = 8'hFC;  // K28.7

    // TS identifiers carried in symbols 6-15
    localparam logic [7:0] TS1_ID = 8'h4A;  // D10.2
    localparam logic [7:0] TS2_ID = 8'h45;  // D5.2

    typedef enum logic [1:0] {
        RATE_2_5GT  = 2'd0,
        RATE_5_0GT  = 2'd1,
        RATE_8_0GT  = 2'd2,
        RATE_16_0GT = 2'd3
    } active_data_rate_e;

    typedef enum logic [2:0] {
        StHunt,
        StOsType,
        StTsBody,
        StSkpBody,
        StEiosBody,
        StFtsBody
    } rx_os_fsm_e;

    typedef struct packed {
        logic       ts_type;      // 0 = TS1, 1 = TS2
        logic [7:0] link_num;
        logic       link_is_pad;
        logic [7:0] lane_num;
        logic       lane_is_pad;
        logic [7:0] n_fts;
        logic [7:0] rate_id;
        logic [7:0] train_ctrl;
    } ts_fields_t;

    // True when the symbol is the given K-code
    function automatic logic is_kcode(input logic [7:0] sym, input logic is_k,
                                      input logic [7:0] code);
        return is_k && (sym == code);
    endfunction

endpackage

// File: rtl/packet_disassembly.sv
// Receive-side ordered-set disassembler for one lane at 2.5/5.0 GT/s.
// Recognises TS1/TS2, SKP, EIOS and FTS ordered sets from decoded symbols,
// extracts TS fields and tracks the number of consecutive identical TSs.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   active_data_rate_i     current link rate; non-8b/10b rates gate the FSM
//   symbol_i/_is_k_i/_valid_i  decoded symbol stream
//   ts_valid_o, ts_type_o, link/lane/n_fts/rate_id/train_ctrl  TS results
//   ts_consec_cnt_o        consecutive identical TS count (saturating)
//   skp_det_o/skp_cnt_o, eios_det_o, fts_det_o, os_err_o  one-cycle pulses
module packet_disassembly
    import packet_disassembly_pkg::*;
#(
    parameter int unsigned TS_CNT_W = 4,
    parameter int unsigned MAX_SKP  = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  active_data_rate_e   active_data_rate_i,
    input  logic [7:0]          symbol_i,
    input  logic                symbol_is_k_i,
    input  logic                symbol_valid_i,
    output logic                ts_valid_o,
    output logic                ts_type_o,
    output logic [7:0]          link_num_o,
    output logic                link_is_pad_o,
    output logic [7:0]          lane_num_o,
    output logic                lane_is_pad_o,
    output logic [7:0]          n_fts_o,
    output logic [7:0]          rate_id_o,
    output logic [7:0]          train_ctrl_o,
    output logic [TS_CNT_W-1:0] ts_consec_cnt_o,
    output logic                skp_det_o,
    output logic [2:0]          skp_cnt_o,
    output logic                eios_det_o,
    output logic                fts_det_o,
    output logic                os_err_o
);

    localparam logic [TS_CNT_W-1:0] CntMax  = '1;
    localparam logic [2:0]          MaxSkp3 = 3'(MAX_SKP);

    rx_os_fsm_e          state_q;
    logic [3:0]          idx_q;       // index of the next expected symbol
    logic [2:0]          skp_run_q;   // SKPs seen in the current SKP OS
    ts_fields_t          cap_q;       // staging for the TS being received
    ts_fields_t          out_q;       // last complete TS, doubles as compare shadow
    logic                prev_valid_q;
    logic [TS_CNT_W-1:0] cnt_q;

    logic                rate_ok;
    logic                is_com, is_skp, is_idl, is_fts, is_pad, is_d;
    logic                ts_sym_ok;
    logic [7:0]          ts_id_exp;
    logic [2:0]          skp_nxt;
    logic [TS_CNT_W-1:0] cnt_nxt;

    always_comb begin
        rate_ok   = (active_data_rate_i == RATE_2_5GT) || (active_data_rate_i == RATE_5_0GT);
        is_com    = is_kcode(symbol_i, symbol_is_k_i, COM);
        is_skp    = is_kcode(symbol_i, symbol_is_k_i, SKP);
        is_idl    = is_kcode(symbol_i, symbol_is_k_i, IDL);
        is_fts    = is_kcode(symbol_i, symbol_is_k_i, FTS);
        is_pad    = is_kcode(symbol_i, symbol_is_k_i, PAD);
        is_d      = !symbol_is_k_i;
        ts_id_exp = cap_q.ts_type ? TS2_ID : TS1_ID;
        skp_nxt   = skp_run_q + 3'd1;

        // Per-index legality of the symbol inside a TS body
        ts_sym_ok = 1'b0;
        case (idx_q)
            4'd2:                ts_sym_ok = is_d || is_pad;
            4'd3, 4'd4, 4'd5:    ts_sym_ok = is_d;
            4'd6:                ts_sym_ok = is_d && (symbol_i == TS1_ID || symbol_i == TS2_ID);
            default:             ts_sym_ok = is_d && (symbol_i == ts_id_exp);
        endcase

        // The finished TS is exactly cap_q: symbols 7-15 only confirm the identifier
        if (prev_valid_q && (cap_q == out_q)) begin
            cnt_nxt = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_nxt = TS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StHunt;
            idx_q        <= '0;
            skp_run_q    <= '0;
            cap_q        <= '0;
            out_q        <= '0;
            prev_valid_q <= 1'b0;
            cnt_q        <= '0;
            ts_valid_o   <= 1'b0;
            skp_det_o    <= 1'b0;
            skp_cnt_o    <= '0;
            eios_det_o   <= 1'b0;
            fts_det_o    <= 1'b0;
            os_err_o     <= 1'b0;
        end else begin
            ts_valid_o <= 1'b0;
            skp_det_o  <= 1'b0;
            eios_det_o <= 1'b0;
            fts_det_o  <= 1'b0;
            os_err_o   <= 1'b0;

            if (!rate_ok) begin
                state_q <= StHunt;
            end else if (symbol_valid_i) begin
                case (state_q)
                    StHunt: begin
                        if (is_com) state_q <= StOsType;
                    end

                    StOsType: begin
                        if (is_skp) begin
                            if (MAX_SKP <= 32'd1) begin
                                skp_det_o <= 1'b1;
                                skp_cnt_o <= 3'd1;
                                state_q   <= StHunt;
                            end else begin
                                skp_run_q <= 3'd1;
                                state_q   <= StSkpBody;
                            end
                        end else if (is_idl) begin
                            idx_q   <= 4'd2;
                            state_q <= StEiosBody;
                        end else if (is_fts) begin
                            idx_q   <= 4'd2;
                            state_q <= StFtsBody;
                        end else if (is_d || is_pad) begin
                            cap_q.link_num    <= symbol_i;
                            cap_q.link_is_pad <= is_pad;
                            idx_q             <= 4'd2;
                            state_q           <= StTsBody;
                        end else begin
                            // COM resynchronises onto a fresh ordered set
                            os_err_o <= 1'b1;
                            state_q  <= is_com ? StOsType : StHunt;
                        end
                    end

                    StTsBody: begin
                        if (ts_sym_ok) begin
                            case (idx_q)
                                4'd2: begin
                                    cap_q.lane_num    <= symbol_i;
                                    cap_q.lane_is_pad <= is_pad;
                                end
                                4'd3:    cap_q.n_fts      <= symbol_i;
                                4'd4:    cap_q.rate_id    <= symbol_i;
                                4'd5:    cap_q.train_ctrl <= symbol_i;
                                4'd6:    cap_q.ts_type    <= (symbol_i == TS2_ID);
                                default: ;
                            endcase
                            if (idx_q == 4'd15) begin
                                ts_valid_o   <= 1'b1;
                                out_q        <= cap_q;
                                prev_valid_q <= 1'b1;
                                cnt_q        <= cnt_nxt;
                                state_q      <= StHunt;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end else begin
                            os_err_o <= 1'b1;
                            state_q  <= is_com ? StOsType : StHunt;
                        end
                    end

                    StSkpBody: begin
                        if (is_skp) begin
                            if (skp_nxt >= MaxSkp3) begin
                                skp_det_o <= 1'b1;
                                skp_cnt_o <= skp_nxt;
                                state_q   <= StHunt;
                            end else begin
                                skp_run_q <= skp_nxt;
                            end
                        end else begin
                            // Terminating symbol is handled as if seen in HUNT
                            skp_det_o <= 1'b1;
                            skp_cnt_o <= skp_run_q;
                            state_q   <= is_com ? StOsType : StHunt;
                        end
                    end

                    StEiosBody, StFtsBody: begin
                        if ((state_q == StEiosBody) ? is_idl : is_fts) begin
                            if (idx_q == 4'd3) begin
                                if (state_q == StEiosBody) begin
                                    eios_det_o <= 1'b1;
                                    cnt_q      <= '0;
                                end else begin
                                    fts_det_o <= 1'b1;
                                end
                                state_q <= StHunt;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end else begin
                            os_err_o <= 1'b1;
                            state_q  <= is_com ? StOsType : StHunt;
                        end
                    end

                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    assign ts_type_o       = out_q.ts_type;
    assign link_num_o      = out_q.link_num;
    assign link_is_pad_o   = out_q.link_is_pad;
    assign lane_num_o      = out_q.lane_num;
    assign lane_is_pad_o   = out_q.lane_is_pad;
    assign n_fts_o         = out_q.n_fts;
    assign rate_id_o       = out_q.rate_id;
    assign train_ctrl_o    = out_q.train_ctrl;
    assign ts_consec_cnt_o = cnt_q;

endmodule

// File: tb/tb_packet_disassembly.sv
// Directed self-checking bench for packet_disassembly.
module tb_packet_disassembly;
    import packet_disassembly_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    active_data_rate_e rate = RATE_2_5GT;
    logic [7:0]        sym = 8'h00;
    logic              sym_k = 1'b0;
    logic              sym_v = 1'b0;

    logic       ts_valid, ts_type, link_pad, lane_pad, skp_det, eios_det, fts_det, os_err;
    logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctrl;
    logic [3:0] cnt;
    logic [2:0] skp_cnt;

    int n_checks = 0;
    int n_err = 0;
    int n_pulse = 0;
    int snap;

    logic       os_k [16];
    logic [7:0] os_d [16];

    packet_disassembly #(.TS_CNT_W(4), .MAX_SKP(5)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .active_data_rate_i (rate),
        .symbol_i           (sym),
        .symbol_is_k_i      (sym_k),
        .symbol_valid_i     (sym_v),
        .ts_valid_o         (ts_valid),
        .ts_type_o          (ts_type),
        .link_num_o         (link_num),
        .link_is_pad_o      (link_pad),
        .lane_num_o         (lane_num),
        .lane_is_pad_o      (lane_pad),
        .n_fts_o            (n_fts),
        .rate_id_o          (rate_id),
        .train_ctrl_o       (train_ctrl),
        .ts_consec_cnt_o    (cnt),
        .skp_det_o          (skp_det),
        .skp_cnt_o          (skp_cnt),
        .eios_det_o         (eios_det),
        .fts_det_o          (fts_det),
        .os_err_o           (os_err)
    );

    always #5 clk = ~clk;

    // Count every pulse of any kind, sampled away from the active edge
    always @(negedge clk) begin
        n_pulse = n_pulse + int'(ts_valid) + int'(skp_det) + int'(eios_det)
                + int'(fts_det) + int'(os_err);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic k, input logic [7:0] d);
        @(negedge clk);
        sym_v = 1'b1;
        sym_k = k;
        sym   = d;
        @(posedge clk);
        #1;
        sym_v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build_ts(input logic [7:0] id, input logic lpad, input logic [7:0] link,
                            input logic npad, input logic [7:0] lane, input logic [7:0] nf,
                            input logic [7:0] rid, input logic [7:0] ctl);
        os_k[0] = 1'b1; os_d[0] = COM;
        os_k[1] = lpad; os_d[1] = lpad ? PAD : link;
        os_k[2] = npad; os_d[2] = npad ? PAD : lane;
        os_k[3] = 1'b0; os_d[3] = nf;
        os_k[4] = 1'b0; os_d[4] = rid;
        os_k[5] = 1'b0; os_d[5] = ctl;
        for (int i = 6; i < 16; i++) begin
            os_k[i] = 1'b0;
            os_d[i] = id;
        end
    endtask

    task automatic send(input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            put(os_k[i], os_d[i]);
            if (gap && i != hi) idle(1);
        end
    endtask

    task automatic check_ts(input string tag, input logic typ, input logic lpad,
                            input logic [7:0] link, input logic npad, input logic [7:0] lane,
                            input logic [7:0] nf, input logic [7:0] rid, input logic [7:0] ctl,
                            input logic [3:0] c);
        chk({tag, ".valid"}, 64'(ts_valid), 64'd1);
        chk({tag, ".type"}, 64'(ts_type), 64'(typ));
        chk({tag, ".link"}, {55'd0, link_pad, link_num}, {55'd0, lpad, link});
        chk({tag, ".lane"}, {55'd0, lane_pad, lane_num}, {55'd0, npad, lane});
        chk({tag, ".body"}, {40'd0, n_fts, rate_id, train_ctrl}, {40'd0, nf, rid, ctl});
        chk({tag, ".cnt"}, 64'(cnt), 64'(c));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({ts_valid, ts_type, link_num, link_pad, lane_num, lane_pad, n_fts, rate_id,
                    train_ctrl, cnt, skp_det, skp_cnt, eios_det, fts_det, os_err});
    endfunction

    initial begin
        // Reset
        idle(3);
        chk("reset_outs", all_outs(), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(1);

        // Single TS1
        build_ts(TS1_ID, 1'b0, 8'h00, 1'b0, 8'h01, 8'h20, 8'h02, 8'h00);
        send(0, 14, 1'b0);
        chk("ts1_not_early", 64'(ts_valid), 64'd0);
        send(15, 15, 1'b0);
        check_ts("ts1", 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h20, 8'h02, 8'h00, 4'd1);
        idle(1);
        chk("ts1_pulse_width", 64'(ts_valid), 64'd0);

        // 8 identical TS2 with PAD link, then a lane change, then saturation
        build_ts(TS2_ID, 1'b1, 8'h00, 1'b0, 8'h00, 8'h40, 8'h06, 8'h01);
        for (int n = 1; n <= 8; n++) begin
            send(0, 15, 1'b0);
            chk("ts2_run_cnt", 64'(cnt), 64'(n));
        end
        check_ts("ts2_8th", 1'b1, 1'b1, PAD, 1'b0, 8'h00, 8'h40, 8'h06, 8'h01, 4'd8);
        build_ts(TS2_ID, 1'b1, 8'h00, 1'b0, 8'h02, 8'h40, 8'h06, 8'h01);
        send(0, 15, 1'b0);
        check_ts("ts2_lane2", 1'b1, 1'b1, PAD, 1'b0, 8'h02, 8'h40, 8'h06, 8'h01, 4'd1);
        for (int n = 0; n < 20; n++) begin
            send(0, 15, 1'b0);
            chk("ts2_sat_cnt", 64'(cnt), (n + 2 > 15) ? 64'd15 : 64'(n + 2));
        end

        // SKP OS terminated by the COM of a TS1
        put(1'b1, COM);
        put(1'b1, SKP);
        put(1'b1, SKP);
        put(1'b1, SKP);
        chk("skp_not_early", 64'(skp_det), 64'd0);
        put(1'b1, COM);
        chk("skp3_det", {60'd0, skp_det, skp_cnt}, {60'd0, 1'b1, 3'd3});
        build_ts(TS1_ID, 1'b0, 8'h00, 1'b0, 8'h01, 8'h20, 8'h02, 8'h00);
        send(1, 15, 1'b0);
        check_ts("ts1_after_skp", 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h20, 8'h02, 8'h00, 4'd1);
        for (int n = 2; n <= 5; n++) send(0, 15, 1'b0);
        chk("ts1_x5_cnt", 64'(cnt), 64'd5);

        // EIOS clears the counter, FTS leaves it alone
        put(1'b1, COM);
        put(1'b1, IDL);
        put(1'b1, IDL);
        chk("eios_not_early", 64'(eios_det), 64'd0);
        put(1'b1, IDL);
        chk("eios_det", {62'd0, eios_det, os_err}, {62'd0, 1'b1, 1'b0});
        chk("eios_cnt", 64'(cnt), 64'd0);
        put(1'b1, COM);
        put(1'b1, FTS);
        put(1'b1, FTS);
        put(1'b1, FTS);
        chk("fts_det", {62'd0, fts_det, eios_det}, {62'd0, 1'b1, 1'b0});
        chk("fts_cnt", 64'(cnt), 64'd0);

        // SKP OS at its maximum length ends without a terminator
        put(1'b1, COM);
        for (int n = 0; n < 4; n++) put(1'b1, SKP);
        chk("skp4_quiet", 64'(skp_det), 64'd0);
        put(1'b1, SKP);
        chk("skp_max_det", {60'd0, skp_det, skp_cnt}, {60'd0, 1'b1, 3'd5});
        put(1'b1, SKP);
        chk("skp_max_hunt", {62'd0, skp_det, os_err}, 64'd0);

        // TS corrupted at symbol 9 leaves fields alone
        build_ts(TS1_ID, 1'b0, 8'h00, 1'b0, 8'h03, 8'h20, 8'h02, 8'h00);
        os_d[9] = TS2_ID;
        send(0, 9, 1'b0);
        chk("corrupt_err", {62'd0, os_err, ts_valid}, {62'd0, 1'b1, 1'b0});
        chk("corrupt_lane_held", 64'(lane_num), 64'h01);
        os_d[9] = TS1_ID;
        send(0, 15, 1'b0);
        check_ts("clean_b", 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 8'h20, 8'h02, 8'h00, 4'd1);

        // TS interrupted by COM at symbol 4 resynchronises on that COM
        build_ts(TS1_ID, 1'b0, 8'h00, 1'b0, 8'h05, 8'h20, 8'h02, 8'h00);
        send(0, 3, 1'b0);
        put(1'b1, COM);
        chk("com_abort_err", 64'(os_err), 64'd1);
        chk("com_abort_lane_held", 64'(lane_num), 64'h03);
        build_ts(TS1_ID, 1'b0, 8'h00, 1'b0, 8'h03, 8'h20, 8'h02, 8'h00);
        send(1, 15, 1'b0);
        check_ts("resync_b", 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 8'h20, 8'h02, 8'h00, 4'd2);

        // Valid toggling every other cycle
        send(0, 15, 1'b1);
        check_ts("gappy_b", 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 8'h20, 8'h02, 8'h00, 4'd3);

        // Reset mid-TS
        send(0, 8, 1'b0);
        snap = n_pulse;
        @(negedge clk) rst_n = 1'b0;
        sym_v = 1'b1;
        sym_k = os_k[9];
        sym   = os_d[9];
        @(posedge clk);
        #1;
        chk("midreset_outs", all_outs(), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        sym_v = 1'b0;
        send(10, 15, 1'b0);
        idle(1);
        chk("midreset_no_pulse", 64'(n_pulse - snap), 64'd0);
        send(0, 15, 1'b0);
        check_ts("post_reset_b", 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 8'h20, 8'h02, 8'h00, 4'd1);

        // Rate gating at 8 GT/s
        send(0, 7, 1'b0);
        idle(1);
        snap = n_pulse;
        rate = RATE_8_0GT;
        send(8, 15, 1'b0);
        send(0, 15, 1'b0);
        idle(1);
        chk("gated_no_pulse", 64'(n_pulse - snap), 64'd0);
        chk("gated_hold", {52'd0, lane_num, cnt}, {52'd0, 8'h03, 4'd1});
        rate = RATE_5_0GT;
        send(8, 15, 1'b0);
        chk("restored_partial_dropped", 64'(ts_valid), 64'd0);
        send(0, 15, 1'b0);
        check_ts("restored_b", 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 8'h20, 8'h02, 8'h00, 4'd2);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
